// File: rtl/ball_motion_ctl_pkg.sv
// rtl/ball_motion_ctl_pkg.sv - rink geometry, rally states and velocity helpers
// Shared by the puck, mallet and score blocks.
package ball_motion_ctl_pkg;

  localparam int RADIUS_BALL     = 10;
  localparam int X_MIN           = 0;
  localparam int X_MAX           = 1023;
  localparam int Y_MIN           = 0;
  localparam int Y_MAX           = 767;
  localparam int GOAL_Y_MIN      = 284;
  localparam int GOAL_Y_MAX      = 484;
  localparam int X_START         = 512;
  localparam int Y_START         = 384;
  localparam int SERVE_FRAMES    = 60;
  localparam int GOAL_FRAMES     = 120;
  localparam int FRICTION_FRAMES = 8;
  localparam int VEL_W           = 6;

  typedef logic signed [VEL_W-1:0] vel_t;

  localparam vel_t SERVE_VX  = 6'sd3;
  localparam vel_t MAX_SPEED = 6'sd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_GOAL
  } ball_state_e;

  // Symmetric saturation keeps -v representable for every clamped v.
  function automatic vel_t vel_clamp(vel_t v);
    vel_t r;
    r = v;
    if (v > MAX_SPEED) r = MAX_SPEED;
    else if (v < -MAX_SPEED) r = -MAX_SPEED;
    return r;
  endfunction

  function automatic vel_t vel_decay(vel_t v);
    vel_t r;
    r = v;
    if (v > 6'sd0) r = v - 6'sd1;
    else if (v < 6'sd0) r = v + 6'sd1;
    return r;
  endfunction

endpackage

// File: rtl/ball_motion_ctl_if.sv
// rtl/ball_motion_ctl_if.sv - frame/hit inputs and puck outputs of the puck controller
interface ball_motion_ctl_if;
  import ball_motion_ctl_pkg::*;

  logic        vblnk_in;
  logic        start_in;
  logic        hit_in;
  vel_t        hit_vx;
  vel_t        hit_vy;
  logic [11:0] xpos_ball;
  logic [11:0] ypos_ball;
  logic        goal_left;
  logic        goal_right;
  logic        in_play;

  modport master (
    output vblnk_in, start_in, hit_in, hit_vx, hit_vy,
    input  xpos_ball, ypos_ball, goal_left, goal_right, in_play
  );

  modport slave (
    input  vblnk_in, start_in, hit_in, hit_vx, hit_vy,
    output xpos_ball, ypos_ball, goal_left, goal_right, in_play
  );

endinterface

// File: rtl/ball_motion_ctl_wall_reflect.sv
// rtl/ball_motion_ctl_wall_reflect.sv - one-frame puck move with wall reflection and goal detect
module ball_motion_ctl_wall_reflect
  import ball_motion_ctl_pkg::*;
(
  input  logic [11:0] x_i,
  input  logic [11:0] y_i,
  input  vel_t        vx_i,
  input  vel_t        vy_i,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output vel_t        vx_o,
  output vel_t        vy_o,
  output logic        goal_left_o,
  output logic        goal_right_o
);

  localparam logic signed [13:0] X_LO = 14'(X_MIN + RADIUS_BALL);
  localparam logic signed [13:0] X_HI = 14'(X_MAX - RADIUS_BALL);
  localparam logic signed [13:0] Y_LO = 14'(Y_MIN + RADIUS_BALL);
  localparam logic signed [13:0] Y_HI = 14'(Y_MAX - RADIUS_BALL);

  logic signed [13:0] nx;
  logic signed [13:0] ny;
  logic [11:0]        y_c;
  logic               in_mouth;

  always_comb begin
    nx = $signed({2'b00, x_i}) + $signed({{8{vx_i[5]}}, vx_i});
    ny = $signed({2'b00, y_i}) + $signed({{8{vy_i[5]}}, vy_i});

    y_c  = ny[11:0];
    vy_o = vy_i;
    if (ny < Y_LO) begin
      y_c  = 12'(Y_MIN + RADIUS_BALL);
      vy_o = -vy_i;
    end else if (ny > Y_HI) begin
      y_c  = 12'(Y_MAX - RADIUS_BALL);
      vy_o = -vy_i;
    end

    // The goal mouth test uses the already wall-clamped y so corners behave.
    in_mouth     = (y_c >= 12'(GOAL_Y_MIN)) && (y_c <= 12'(GOAL_Y_MAX));
    x_o          = nx[11:0];
    vx_o         = vx_i;
    goal_left_o  = 1'b0;
    goal_right_o = 1'b0;
    if (nx < X_LO) begin
      x_o = 12'(X_MIN + RADIUS_BALL);
      if (in_mouth) goal_left_o = 1'b1;
      else vx_o = -vx_i;
    end else if (nx > X_HI) begin
      x_o = 12'(X_MAX - RADIUS_BALL);
      if (in_mouth) goal_right_o = 1'b1;
      else vx_o = -vx_i;
    end
    y_o = y_c;
  end

endmodule

// File: rtl/ball_motion_ctl.sv
// rtl/ball_motion_ctl.sv - per-frame puck controller: rally FSM, hit latch, position/velocity
// Optional feature: BALL_FRICTION_EN slows the puck by 1 every FRICTION_FRAMES play frames.
module ball_motion_ctl
  import ball_motion_ctl_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst,
  ball_motion_ctl_if.slave bif
);

  localparam logic [6:0]  SERVE_LAST = 7'(SERVE_FRAMES - 1);
  localparam logic [6:0]  GOAL_LAST  = 7'(GOAL_FRAMES - 1);
`ifdef BALL_FRICTION_EN
  localparam logic [6:0]  FRIC_LAST  = 7'(FRICTION_FRAMES - 1);
`endif
  localparam logic [11:0] X_HOME     = 12'(X_START);
  localparam logic [11:0] Y_HOME     = 12'(Y_START);

  ball_state_e state_q, state_d;
  logic [6:0]  count_q, count_d;
  logic        serve_pos_q, serve_pos_d;
  logic        vblnk_prev_q;
  logic        hit_pend_q, hit_pend_d;
  vel_t        hit_vx_q, hit_vx_d, hit_vy_q, hit_vy_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  vel_t        vx_q, vx_d, vy_q, vy_d;
  logic        goal_left_q, goal_left_d, goal_right_q, goal_right_d;

  logic        tick, hit_now;
  vel_t        vx_pre, vy_pre, rf_vx, rf_vy;
  logic [11:0] rf_x, rf_y;
  logic        rf_goal_left, rf_goal_right;

  assign tick    = bif.vblnk_in & ~vblnk_prev_q;
  // A hit arriving on the tick cycle itself takes effect on that tick.
  assign hit_now = bif.hit_in | hit_pend_q;
  assign vx_pre  = hit_now ? vel_clamp(bif.hit_in ? bif.hit_vx : hit_vx_q) : vx_q;
  assign vy_pre  = hit_now ? vel_clamp(bif.hit_in ? bif.hit_vy : hit_vy_q) : vy_q;

  ball_motion_ctl_wall_reflect u_reflect (
    .x_i          (x_q),
    .y_i          (y_q),
    .vx_i         (vx_pre),
    .vy_i         (vy_pre),
    .x_o          (rf_x),
    .y_o          (rf_y),
    .vx_o         (rf_vx),
    .vy_o         (rf_vy),
    .goal_left_o  (rf_goal_left),
    .goal_right_o (rf_goal_right)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    serve_pos_d  = serve_pos_q;
    x_d          = x_q;
    y_d          = y_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    goal_left_d  = 1'b0;
    goal_right_d = 1'b0;
    hit_pend_d   = hit_pend_q;
    hit_vx_d     = hit_vx_q;
    hit_vy_d     = hit_vy_q;

    if (bif.hit_in) begin
      hit_pend_d = 1'b1;
      hit_vx_d   = bif.hit_vx;
      hit_vy_d   = bif.hit_vy;
    end

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (bif.start_in) begin
            state_d     = ST_SERVE;
            count_d     = 7'd0;
            serve_pos_d = 1'b1;
          end
        end
        ST_SERVE: begin
          if (count_q == SERVE_LAST) begin
            state_d = ST_PLAY;
            count_d = 7'd0;
            vx_d    = serve_pos_q ? SERVE_VX : -SERVE_VX;
            vy_d    = '0;
          end else begin
            count_d = count_q + 7'd1;
          end
        end
        ST_PLAY: begin
          x_d        = rf_x;
          y_d        = rf_y;
          vx_d       = rf_vx;
          vy_d       = rf_vy;
          hit_pend_d = 1'b0;
          if (rf_goal_left || rf_goal_right) begin
            state_d      = ST_GOAL;
            count_d      = 7'd0;
            goal_left_d  = rf_goal_left;
            goal_right_d = rf_goal_right;
            // Next serve heads toward the scorer, i.e. away from the conceding goal.
            serve_pos_d  = rf_goal_left;
          end
`ifdef BALL_FRICTION_EN
          else if (count_q == FRIC_LAST) begin
            count_d = 7'd0;
            vx_d    = vel_decay(rf_vx);
            vy_d    = vel_decay(rf_vy);
          end else begin
            count_d = count_q + 7'd1;
          end
`endif
        end
        ST_GOAL: begin
          if (count_q == GOAL_LAST) begin
            state_d = ST_SERVE;
            count_d = 7'd0;
            x_d     = X_HOME;
            y_d     = Y_HOME;
            vx_d    = '0;
            vy_d    = '0;
          end else begin
            count_d = count_q + 7'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (state_d != state_q) hit_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= 7'd0;
      serve_pos_q  <= 1'b1;
      vblnk_prev_q <= 1'b0;
      hit_pend_q   <= 1'b0;
      hit_vx_q     <= '0;
      hit_vy_q     <= '0;
      x_q          <= X_HOME;
      y_q          <= Y_HOME;
      vx_q         <= '0;
      vy_q         <= '0;
      goal_left_q  <= 1'b0;
      goal_right_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      serve_pos_q  <= serve_pos_d;
      vblnk_prev_q <= bif.vblnk_in;
      hit_pend_q   <= hit_pend_d;
      hit_vx_q     <= hit_vx_d;
      hit_vy_q     <= hit_vy_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      goal_left_q  <= goal_left_d;
      goal_right_q <= goal_right_d;
    end
  end

  assign bif.xpos_ball  = x_q;
  assign bif.ypos_ball  = y_q;
  assign bif.goal_left  = goal_left_q;
  assign bif.goal_right = goal_right_q;
  assign bif.in_play    = (state_q == ST_PLAY);

endmodule
